muldiv_seq: RTL and testbench

- Multi-cycle sequencer and iterative datapath for the MUL/MUH/MULU/MUHU/DIV/MOD/DIVU/MODU ALU ops.
- Sits beside the single-cycle ALU in EX. The control decoder's alu_op selects the operation. This block owns the shared shift-add multiplier / restoring divider for the duration of the operation and stalls the pipeline until the result is ready.
- One operation in flight at a time.

---
 rtl/muldiv_seq_pkg.sv | 52 +++++
 rtl/muldiv_seq_iter.sv | 67 ++++++
 rtl/muldiv_seq.sv | 140 ++++++++++++++
 tb/tb_muldiv_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: shared ALU op codes, muldiv FSM states, op decode.
// Exports ALU_OP_*, md_state_e, MD_DIV0_Q, md_op_t, md_decode().
package muldiv_seq_pkg;

  localparam logic [5:0] ALU_OP_MUL  = 6'h18;
  localparam logic [5:0] ALU_OP_MUH  = 6'h19;
  localparam logic [5:0] ALU_OP_MULU = 6'h1A;
  localparam logic [5:0] ALU_OP_MUHU = 6'h1B;
  localparam logic [5:0] ALU_OP_DIV  = 6'h1C;
  localparam logic [5:0] ALU_OP_MOD  = 6'h1D;
  localparam logic [5:0] ALU_OP_DIVU = 6'h1E;
  localparam logic [5:0] ALU_OP_MODU = 6'h1F;
  localparam logic [5:0] ALU_OP_ADD  = 6'h20;

  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'd0,
    MD_ST_CALC = 2'd1,
    MD_ST_FIX  = 2'd2,
    MD_ST_DONE = 2'd3
  } md_state_e;

  localparam logic [31:0] MD_DIV0_Q = 32'hFFFF_FFFF;

  // sel: high word for multiply, remainder for divide
  typedef struct packed {
    logic vld;
    logic div;
    logic sel;
    logic sgn;
  } md_op_t;

  function automatic md_op_t md_decode(input logic [5:0] op);
    md_op_t d;
    d = '0;
    d.vld = 1'b1;
    case (op)
      ALU_OP_MUL:  d.sgn = 1'b1;
      ALU_OP_MUH:  begin d.sel = 1'b1; d.sgn = 1'b1; end
      ALU_OP_MULU: d.sgn = 1'b0;
      ALU_OP_MUHU: d.sel = 1'b1;
      ALU_OP_DIV:  begin d.div = 1'b1; d.sgn = 1'b1; end
      ALU_OP_MOD:  begin
        d.div = 1'b1; d.sel = 1'b1; d.sgn = 1'b1;
      end
      ALU_OP_DIVU: d.div = 1'b1;
      ALU_OP_MODU: begin d.div = 1'b1; d.sel = 1'b1; end
      default:     d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/muldiv_seq_iter.sv
// muldiv_seq_iter: shift-add multiply / restoring divide, one step per clk.
// In: load/step/div_mode, opa, opb, rem_init. Out: acc (prod or quotient), rem.
module muldiv_seq_iter
  import muldiv_seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                step,
  input  logic                div_mode,
  input  logic [DATA_W-1:0]   opa,
  input  logic [DATA_W-1:0]   opb,
  input  logic [DATA_W-1:0]   rem_init,
  output logic [2*DATA_W-1:0] acc,
  output logic [DATA_W-1:0]   rem
);

  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     shl;
  logic [DATA_W+1:0]   diff;

  always_comb begin
    acc_d = acc_q;
    opb_d = opb_q;
    rem_d = rem_q;
    sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
          + {1'b0, (acc_q[0] ? opb_q : '0)};
    // 33-bit partial remainder: old rem shifted, next dividend bit in
    shl   = {rem_q, acc_q[DATA_W-1]};
    diff  = {1'b0, shl} - {2'b0, opb_q};
    if (load) begin
      acc_d = {{DATA_W{1'b0}}, opa};
      opb_d = opb;
      rem_d = rem_init;
    end else if (step) begin
      if (div_mode) begin
        rem_d = diff[DATA_W+1] ? shl[DATA_W-1:0]
                               : diff[DATA_W-1:0];
        acc_d = {acc_q[2*DATA_W-1:DATA_W],
                 acc_q[DATA_W-2:0], ~diff[DATA_W+1]};
      end else begin
        acc_d = {sum, acc_q[DATA_W-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      opb_q <= '0;
      rem_q <= '0;
    end else begin
      acc_q <= acc_d;
      opb_q <= opb_d;
      rem_q <= rem_d;
    end
  end

  assign acc = acc_q;
  assign rem = rem_q;

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MUL/MUH/DIV/MOD sequencer with sign fix-up.
// In: start, alu_op, src_a, src_b, kill. Out: busy, stall, done, result.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [5:0]        alu_op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              kill,
  output logic              busy,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  md_op_t            op_q, op_d, dec;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic              div0_q, div0_d;
  logic [DATA_W-1:0] result_q, result_d;

  logic                accept, a_neg, b_neg, div0;
  logic                busy_w, idle_w;
  logic [DATA_W-1:0]   mag_a, mag_b, rem_init;
  logic [DATA_W-1:0]   fix_q, fix_r, fix_w;
  logic [2*DATA_W-1:0] acc, prod;
  logic [DATA_W-1:0]   rem;

  always_comb begin
    dec      = md_decode(alu_op);
    a_neg    = dec.sgn & src_a[DATA_W-1];
    b_neg    = dec.sgn & src_b[DATA_W-1];
    // -0x80000000 wraps to 0x80000000, the correct unsigned magnitude
    mag_a    = a_neg ? -src_a : src_a;
    mag_b    = b_neg ? -src_b : src_b;
    div0     = dec.div & (src_b == '0);
    busy_w   = (state_q == MD_ST_CALC) | (state_q == MD_ST_FIX);
    idle_w   = (state_q == MD_ST_IDLE) | (state_q == MD_ST_DONE);
    accept   = start & ~kill & dec.vld & idle_w;
    // div0 remainder: |a| re-signed by neg_r gives src_a back
    rem_init = div0 ? mag_a : '0;
    prod     = negq_q ? -acc : acc;
    fix_q    = div0_q ? MD_DIV0_Q
             : (negq_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0]);
    fix_r    = negr_q ? -rem : rem;
    if (op_q.div)
      fix_w = op_q.sel ? fix_r : fix_q;
    else
      fix_w = op_q.sel ? prod[2*DATA_W-1:DATA_W]
                       : prod[DATA_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    div0_d   = div0_q;
    result_d = result_q;
    unique case (state_q)
      MD_ST_IDLE, MD_ST_DONE: begin
        state_d = MD_ST_IDLE;
        if (accept) begin
          state_d = div0 ? MD_ST_FIX : MD_ST_CALC;
          cnt_d   = '0;
          op_d    = dec;
          negq_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
          div0_d  = div0;
        end
      end
      MD_ST_CALC: begin
        if (cnt_q == CNT_W'(DATA_W-1)) begin
          state_d = MD_ST_FIX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MD_ST_FIX: begin
        result_d = fix_w;
        state_d  = MD_ST_DONE;
      end
      default: state_d = MD_ST_IDLE;
    endcase
    if (kill && busy_w) begin
      state_d  = MD_ST_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MD_ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      div0_q   <= div0_d;
      result_q <= result_d;
    end
  end

  muldiv_seq_iter #(.DATA_W(DATA_W)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .step     (state_q == MD_ST_CALC),
    .div_mode (op_q.div),
    .opa      (mag_a),
    .opb      (mag_b),
    .rem_init (rem_init),
    .acc      (acc),
    .rem      (rem)
  );

  assign busy   = busy_w;
  assign done   = (state_q == MD_ST_DONE);
  assign stall  = start | busy_w;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed + random checks of muldiv_seq vs arithmetic model.
// Drives at negedge, samples 1ns later; prints one CHECKS/ERRORS summary.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  alu_op = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        kill = 1'b0;
  logic        busy, stall, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .alu_op (alu_op),
    .src_a  (src_a),
    .src_b  (src_b),
    .kill   (kill),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [5:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic               ovf;
    sp  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    up  = {32'b0, a} * {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      ALU_OP_MUL:  return sp[31:0];
      ALU_OP_MUH:  return sp[63:32];
      ALU_OP_MULU: return up[31:0];
      ALU_OP_MUHU: return up[63:32];
      ALU_OP_DIV:
        if (b == 0) return 32'hFFFF_FFFF;
        else if (ovf) return a;
        else return $signed(a) / $signed(b);
      ALU_OP_MOD:
        if (b == 0) return a;
        else if (ovf) return 32'h0;
        else return $signed(a) % $signed(b);
      ALU_OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_OP_MODU: return (b == 0) ? a : a % b;
      default:     return 32'h0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [5:0] op,
                                 input logic [31:0] b);
    return (op >= ALU_OP_DIV && op <= ALU_OP_MODU && b == 0) ? 2 : 34;
  endfunction

  // Called at a negedge; returns 1ns after the negedge of the done cycle.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res,
                        output int lat, output int stl);
    start = 1'b1;
    alu_op = op;
    src_a = a;
    src_b = b;
    #1;
    stl = stall ? 1 : 0;
    @(negedge clk);
    start = 1'b0;
    #1;
    lat = 1;
    while (!done && lat < 100) begin
      if (stall) stl++;
      @(negedge clk);
      #1;
      lat++;
    end
    if (lat >= 100) chk("timeout", 32'(lat), 32'd34);
    res = result;
  endtask

  task automatic do_op(input string tag, input logic [5:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    logic [31:0] r;
    int l, s;
    run_op(op, a, b, r, l, s);
    chk({tag, "_res"}, r, exp);
    chk({tag, "_lat"}, 32'(l), 32'(ref_lat(op, b)));
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r, a, b;
    logic [5:0]  op;
    int l, s, seen;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(ALU_OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, l, s);
    chk("mulu_res", r, 32'h0000_0001);
    chk("mulu_lat", 32'(l), 32'd34);
    chk("mulu_stall_cyc", 32'(s), 32'd34);
    chk("mulu_stall_done", {31'b0, stall}, 32'd0);
    @(negedge clk);
    #1;
    chk("idle_after", {31'b0, done}, 32'd0);
    do_op("muhu", ALU_OP_MUHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFE);

    run_op(ALU_OP_MUL, 32'hFFFF_FFFD, 32'h7, r, l, s);
    chk("mul_res", r, 32'hFFFF_FFEB);
    run_op(ALU_OP_MUH, 32'hFFFF_FFFD, 32'h7, r, l, s);
    chk("b2b_res", r, 32'hFFFF_FFFF);
    chk("b2b_lat", 32'(l), 32'd34);
    @(negedge clk);
    #1;

    do_op("div", ALU_OP_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD);
    do_op("mod", ALU_OP_MOD, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF);
    do_op("divu", ALU_OP_DIVU, 32'hFFFF_FFF9, 32'h2, 32'h7FFF_FFFC);
    do_op("modu", ALU_OP_MODU, 32'hFFFF_FFF9, 32'h2, 32'h0000_0001);
    do_op("divu0", ALU_OP_DIVU, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF);
    do_op("modu0", ALU_OP_MODU, 32'h1234_5678, 32'h0, 32'h1234_5678);
    do_op("div0s", ALU_OP_DIV, 32'h8765_4321, 32'h0, 32'hFFFF_FFFF);
    do_op("mod0s", ALU_OP_MOD, 32'h8765_4321, 32'h0, 32'h8765_4321);
    do_op("divovf", ALU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h8000_0000);
    do_op("modovf", ALU_OP_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

    do_op("prior", ALU_OP_MULU, 32'hAAAA_5555, 32'h1, 32'hAAAA_5555);
    start = 1'b1;
    alu_op = ALU_OP_MUL;
    src_a = 32'h1234;
    src_b = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    chk("kill_busy_pre", {31'b0, busy}, 32'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    #1;
    chk("kill_busy", {31'b0, busy}, 32'd0);
    chk("kill_done", {31'b0, done}, 32'd0);
    chk("kill_res", result, 32'hAAAA_5555);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (done) seen++;
    end
    chk("kill_nodone", 32'(seen), 32'd0);
    chk("kill_res_hold", result, 32'hAAAA_5555);

    start = 1'b1;
    kill = 1'b1;
    alu_op = ALU_OP_DIVU;
    src_b = 32'h0;
    @(negedge clk);
    start = 1'b0;
    kill = 1'b0;
    #1;
    chk("ks_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    #1;
    chk("ks_done", {31'b0, done}, 32'd0);

    run_op(ALU_OP_DIVU, 32'h55, 32'h0, r, l, s);
    chk("kdone_pulse", {31'b0, done}, 32'd1);
    start = 1'b1;
    kill = 1'b1;
    alu_op = ALU_OP_MUL;
    @(negedge clk);
    start = 1'b0;
    kill = 1'b0;
    #1;
    chk("kdone_busy", {31'b0, busy}, 32'd0);
    chk("kdone_done", {31'b0, done}, 32'd0);
    @(negedge clk);

    start = 1'b1;
    alu_op = ALU_OP_DIV;
    src_a = 32'h7777;
    src_b = 32'h3;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_res", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    start = 1'b1;
    alu_op = ALU_OP_ADD;
    #1;
    chk("ill_stall0", {31'b0, stall}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("ill_stall1", {31'b0, stall}, 32'd0);
    chk("ill_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    #1;
    chk("ill_done", {31'b0, done}, 32'd0);
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      op = ALU_OP_MUL + 6'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'h0;
        1:       b = 32'($urandom_range(1, 9));
        2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      do_op($sformatf("rnd%0d_op%0h", i, op), op, a, b,
            ref_md(op, a, b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
